// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: RV32I width codes,
// FSM state encoding and the per-request width/alignment fault check.
package lsu_pkg;

  // RV32I funct3 width codes for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    RESP
  } lsu_state_e;

  // True when the width code is illegal, illegal for a store, or the byte
  // offset is misaligned for the access size. Range checking lives in the top.
  function automatic logic f3_fault(input logic       we,
                                    input logic [2:0] funct3,
                                    input logic [1:0] off);
    logic fault;
    fault = 1'b0;
    case (funct3)
      F3_B:    fault = 1'b0;
      F3_H:    fault = off[0];
      F3_W:    fault = |off;
      F3_BU:   fault = we;
      F3_HU:   fault = we | off[0];
      default: fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/halfword lane handling: extracts and extends load data from a memory
// word, and merges sub-word store data into a word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select, sign/zero extension and store-lane merge
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    byte_sel   = rdata[7:0];
    half_sel   = rdata[15:0];
    load_data  = rdata;
    merge_data = rdata;

    case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h000000, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0000, half_sel};
      default: load_data = rdata;
    endcase

    case (funct3)
      F3_B: begin
        case (off)
          2'd0:    merge_data[7:0]   = wdata[7:0];
          2'd1:    merge_data[15:8]  = wdata[7:0];
          2'd2:    merge_data[23:16] = wdata[7:0];
          default: merge_data[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (off[1]) merge_data[31:16] = wdata[15:0];
        else        merge_data[15:0]  = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between a core and a single-port word memory with a
// one-cycle registered read. Sub-word stores are done as read-modify-write
// because the memory has no byte enables.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        accept;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RESP);
  assign mem_wr_en = (state_q == WRITE);

  assign req_err = f3_fault(req_we, req_funct3, req_addr[1:0]) ||
                   ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));

  // mem_wdata doubles as the latched store data; in WAIT it is replaced by
  // the merged word for sub-word stores.
  lsu_align u_align (
    .funct3     (funct3_q),
    .off        (off_q),
    .rdata      (mem_rdata),
    .wdata      (mem_wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                            state_d = RESP;
          else if (req_we && req_funct3 == F3_W)  state_d = WRITE;
          else                                    state_d = READ;
        end
      end
      READ:    state_d = WAIT;
      WAIT:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request latch, memory address/data and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      funct3_q  <= F3_B;
      off_q     <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        off_q    <= req_addr[1:0];
        mem_addr <= {2'b00, req_addr[31:2]};
        if (req_we && !req_err) mem_wdata <= req_wdata;
        if (req_err) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
      if (state_q == WAIT) begin
        if (we_q) begin
          mem_wdata <= merge_data;
        end else begin
          rsp_rdata <= load_data;
          rsp_err   <= 1'b0;
        end
      end
      if (state_q == WRITE) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed vectors, a reset-abort case,
// back-to-back requests and randomized traffic against a word-array model.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        pre_we;
  logic [9:0]  pre_idx;
  logic [31:0] pre_data;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH_WORDS(1024)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Memory with registered read and a bench preload port
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (mem_wr_en && mem_addr < 32'd1024) mem[mem_addr[9:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural model: result, latency (cycles after accept) and write
  function automatic void model(input logic we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic e, output logic [31:0] rd,
                                output int lat, output int nwr, output logic [31:0] ww);
    int          bytes;
    int          idx;
    int          sh;
    logic [31:0] mask;
    logic [31:0] word;
    logic [31:0] v;
    bytes = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2) ? 4 : 0;
    idx   = int'(a >> 2);
    sh    = 8 * int'(a % 4);
    rd = 32'h0; ww = 32'h0; nwr = 0;
    e = (bytes == 0) || (we && (f3 == 3'd4 || f3 == 3'd5)) || (idx >= 1024);
    if (bytes != 0 && (a % bytes) != 0) e = 1'b1;
    if (e) begin
      lat = 1;
      return;
    end
    mask = (bytes == 1) ? 32'hFF : (bytes == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    word = ref_mem[idx];
    if (!we) begin
      v = (word >> sh) & mask;
      if ((f3 == 3'd0 || f3 == 3'd1) && ((v & ((mask >> 1) + 1)) != 0)) v = v | ~mask;
      rd  = v;
      lat = 3;
    end else begin
      ww  = (word & ~(mask << sh)) | ((wd & mask) << sh);
      ref_mem[idx] = ww;
      nwr = 1;
      lat = (bytes == 4) ? 2 : 4;
    end
  endfunction

  // One request: wait for ready, accept, monitor until the response pulse
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    logic e_exp, er_obs;
    logic [31:0] rd_exp, ww_exp, rd_obs, wr_word, wr_addr;
    int lat_exp, nwr_exp, lat_obs, nwr_obs, wr_cyc, wait_n;
    model(we, f3, a, wd, e_exp, rd_exp, lat_exp, nwr_exp, ww_exp);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    wait_n = 0;
    while (!req_ready && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    check({tag, "/ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat_obs = 0; nwr_obs = 0; wr_cyc = 0;
    rd_obs = 'x; er_obs = 1'bx; wr_word = 'x; wr_addr = 'x;
    for (int c = 1; c <= 8; c++) begin
      if (mem_wr_en) begin
        nwr_obs++;
        wr_cyc  = c;
        wr_word = mem_wdata;
        wr_addr = mem_addr;
      end
      if (rsp_valid) begin
        lat_obs = c;
        rd_obs  = rsp_rdata;
        er_obs  = rsp_err;
        break;
      end
      @(negedge clk);
    end
    check({tag, "/latency"}, 32'(lat_obs), 32'(lat_exp));
    check({tag, "/rdata"}, rd_obs, rd_exp);
    check({tag, "/err"}, 32'(er_obs), 32'(e_exp));
    check({tag, "/writes"}, 32'(nwr_obs), 32'(nwr_exp));
    if (nwr_exp != 0) begin
      check({tag, "/wr_word"}, wr_word, ww_exp);
      check({tag, "/wr_addr"}, wr_addr, {2'b00, a[31:2]});
      check({tag, "/wr_cycle"}, 32'(wr_cyc), 32'(lat_exp - 1));
    end
    last_rd = rd_obs;
    @(negedge clk);
    check({tag, "/rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
    check({tag, "/rdata_hold"}, rsp_rdata, rd_exp);
    check({tag, "/err_hold"}, 32'(rsp_err), 32'(e_exp));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nwr, nrsp, first_rsp, second_rsp, ready_cyc;
    logic [31:0] b2b_data, v, a, wd;
    logic [2:0] codes [8];
    logic [2:0] f3;
    int r;
    codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    // Reset, preloading the first 16 words while it is held
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; pre_we = 1'b0; pre_idx = '0; pre_data = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      v = $urandom;
      pre_we = 1'b1; pre_idx = 10'(i); pre_data = v; ref_mem[i] = v;
    end
    @(negedge clk);
    pre_we = 1'b0;
    @(negedge clk);
    check("reset/req_ready", 32'(req_ready), 32'd1);
    check("reset/rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset/rsp_rdata", rsp_rdata, 32'h0);
    check("reset/rsp_err", 32'(rsp_err), 32'd0);
    check("reset/mem_wr_en", 32'(mem_wr_en), 32'd0);
    check("reset/mem_addr", mem_addr, 32'h0);
    check("reset/mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;

    // Word store
    do_req("sw_deadbeef", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    check("sw_deadbeef/mem_addr_held", mem_addr, 32'd4);
    check("sw_deadbeef/mem_wdata_held", mem_wdata, 32'hDEADBEEF);

    // Loads of each width from word 4 = 0x80FF7F01
    do_req("sw_80ff7f01", 1'b1, 3'b010, 32'h10, 32'h80FF7F01);
    do_req("lb_13", 1'b0, 3'b000, 32'h13, 32'h0);
    check("lb_13/const", last_rd, 32'hFFFFFF80);
    do_req("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0);
    check("lbu_13/const", last_rd, 32'h00000080);
    do_req("lh_10", 1'b0, 3'b001, 32'h10, 32'h0);
    check("lh_10/const", last_rd, 32'h00007F01);
    do_req("lhu_12", 1'b0, 3'b101, 32'h12, 32'h0);
    check("lhu_12/const", last_rd, 32'h000080FF);

    // Sub-word stores via read-modify-write
    do_req("sw_11223344", 1'b1, 3'b010, 32'h10, 32'h11223344);
    do_req("sb_11", 1'b1, 3'b000, 32'h11, 32'h000000AB);
    do_req("sh_12", 1'b1, 3'b001, 32'h12, 32'h0000CAFE);
    do_req("lw_after_rmw", 1'b0, 3'b010, 32'h10, 32'h0);
    check("lw_after_rmw/const", last_rd, 32'hCAFEAB44);

    // Erroneous requests
    do_req("err_lw_02", 1'b0, 3'b010, 32'h02, 32'h0);
    do_req("err_sh_01", 1'b1, 3'b001, 32'h01, 32'h1234);
    do_req("err_f3_011", 1'b0, 3'b011, 32'h10, 32'h0);
    do_req("err_lw_oor", 1'b0, 3'b010, 32'h1000, 32'h0);
    do_req("err_sbu", 1'b1, 3'b100, 32'h10, 32'h55);
    do_req("edge_lw_last", 1'b0, 3'b010, 32'hFFC, 32'h0);

    // Reset asserted during the WAIT of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h11; req_wdata = 32'h55;
    check("rst_wait/ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    nwr = 0; nrsp = 0;
    if (mem_wr_en) nwr++;
    if (rsp_valid) nrsp++;
    @(negedge clk);
    if (mem_wr_en) nwr++;
    if (rsp_valid) nrsp++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_wait/ready_after", 32'(req_ready), 32'd1);
    check("rst_wait/mem_wdata_clr", mem_wdata, 32'h0);
    check("rst_wait/rsp_rdata_clr", rsp_rdata, 32'h0);
    for (int c = 0; c < 6; c++) begin
      if (mem_wr_en) nwr++;
      if (rsp_valid) nrsp++;
      @(negedge clk);
    end
    check("rst_wait/no_write", 32'(nwr), 32'd0);
    check("rst_wait/no_rsp", 32'(nrsp), 32'd0);
    check("rst_wait/ready_idle", 32'(req_ready), 32'd1);
    do_req("rst_wait/word_intact", 1'b0, 3'b010, 32'h10, 32'h0);

    // Back-to-back: valid held across SW then LW to the same address
    wd = $urandom;
    void'($urandom);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = wd;
    ref_mem[8] = wd;
    @(posedge clk);
    @(negedge clk);
    req_we = 1'b0;
    first_rsp = 0; second_rsp = 0; ready_cyc = 0; b2b_data = 'x;
    for (int c = 1; c <= 10; c++) begin
      if (rsp_valid) begin
        if (first_rsp == 0) first_rsp = c;
        else if (second_rsp == 0) begin
          second_rsp = c;
          b2b_data = rsp_rdata;
        end
      end
      if (req_ready && ready_cyc == 0) ready_cyc = c;
      @(posedge clk);
      @(negedge clk);
      if (ready_cyc != 0) req_valid = 1'b0;
    end
    check("b2b/sw_rsp_cycle", 32'(first_rsp), 32'd2);
    check("b2b/lw_accept_cycle", 32'(ready_cyc), 32'd3);
    check("b2b/lw_rsp_cycle", 32'(second_rsp), 32'd6);
    check("b2b/lw_data", b2b_data, wd);

    // Randomized traffic over the first 16 words plus out-of-range hits
    for (int t = 0; t < 40; t++) begin
      r  = int'($urandom_range(0, 11));
      f3 = (r < 8) ? codes[r] : 3'b010;
      a  = ($urandom_range(0, 9) == 0) ? (32'h1000 + 32'($urandom_range(0, 255)))
                                       : 32'($urandom_range(0, 63));
      do_req($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), f3, a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
